axi_master_bridge: RTL and testbench

AXI3 initiator that turns one cache or uncached memory request at a time into an AXI read burst or write burst. It sits inside `mycpu_top` between the cache/uncached arbiter and the top-level AXI master ports, and talks to the `axi_ram` responder. It handles exactly one transaction at a time:

- a read runs AR then R;
- a write runs AW, then W, then B;
- completion is reported with a single-cycle `done` pulse plus an error flag.

---
 rtl/axi_master_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
//
// AXI3 initiator that turns one memory request at a time into a single AXI
// INCR burst. A read runs AR then R. A write runs AW, then W, then B. Every
// transaction ends with a one-cycle `done` pulse, and `err` is qualified by
// that pulse.
//
// Handshake rule used on every channel: a transfer happens on a rising edge
// where valid && ready are both high. A valid that this block drives stays
// high, with its payload stable, until the matching ready is seen. The
// requester side uses the same rule (req_valid / req_ready). The read data
// path has no backpressure: rd_valid mirrors rvalid while in the R state.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_*               request: valid/ready, wr, addr, len (beats-1),
//                       size (log2 bytes), strb (applied to every write beat)
//   rd_valid/data/last  read beats forwarded to the requester
//   wd_idx / wd_data    write-beat index out, matching data back (combinational)
//   done / err          completion pulse and its error flag
//   ar*/r*/aw*/w*/b*    AXI3 master channels
//   state_dbg           current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module axi_master_bridge (
  input  logic        clk,
  input  logic        rst,
  // requester
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strb,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic [7:0]  wd_idx,
  input  logic [31:0] wd_data,
  output logic        done,
  output logic        err,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // observation
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] RD_ID      = 4'd0;
  localparam logic [3:0] WR_ID      = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [3:0]  strb_q;
  logic [7:0]  cnt_q;
  logic        e_q;

  logic        accept;
  logic        cnt_is_last;
  logic        r_beat;
  logic        w_beat;
  logic        b_beat;
  logic        r_bad;
  logic        b_bad;

  assign accept      = (state == S_IDLE) && req_valid;
  assign cnt_is_last = (cnt_q == len_q);
  assign r_beat      = (state == S_R) && rvalid;
  assign w_beat      = (state == S_W) && wready;
  assign b_beat      = (state == S_B) && bvalid;

  // A read beat is bad on an error response, a foreign id, or an rlast that
  // disagrees with the beat count (early or missing last).
  assign r_bad = (rresp != 2'b00) || (rid != RD_ID) || (rlast != cnt_is_last);
  assign b_bad = (bresp != 2'b00) || (bid != WR_ID);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept)                state_nxt = req_wr ? S_AW : S_AR;
      S_AR:   if (arready)               state_nxt = S_R;
      S_R:    if (rvalid && rlast)       state_nxt = S_DONE;
      S_AW:   if (awready)               state_nxt = S_W;
      S_W:    if (wready && cnt_is_last) state_nxt = S_B;
      S_B:    if (bvalid)                state_nxt = S_DONE;
      S_DONE:                            state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request registers, beat counter, sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 32'd0;
      len_q  <= 8'd0;
      size_q <= 3'd0;
      strb_q <= 4'd0;
      cnt_q  <= 8'd0;
      e_q    <= 1'b0;
    end else if (accept) begin
      addr_q <= req_addr;
      len_q  <= req_len;
      size_q <= req_size;
      strb_q <= req_strb;
      cnt_q  <= 8'd0;
      e_q    <= 1'b0;
    end else if (r_beat) begin
      cnt_q <= cnt_q + 8'd1;
      if (r_bad) e_q <= 1'b1;
    end else if (w_beat) begin
      cnt_q <= cnt_q + 8'd1;
    end else if (b_beat) begin
      if (b_bad) e_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all decoded from state and registers)
  // -------------------------------------------------------------------------
  assign req_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && e_q;
  assign state_dbg = state;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == S_AR);

  assign rready   = (state == S_R);
  assign rd_valid = r_beat;
  assign rd_data  = rdata;
  assign rd_last  = (state == S_R) && rlast;

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state == S_AW);

  assign wid    = WR_ID;
  assign wdata  = wd_data;
  assign wstrb  = strb_q;
  assign wlast  = (state == S_W) && cnt_is_last;
  assign wvalid = (state == S_W);
  assign wd_idx = cnt_q;

  assign bready = (state == S_B);

endmodule

// File: tb/tb_axi_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_master_bridge
//
// Single-threaded bench: every input is driven on the falling edge and every
// output is sampled there (or #1 later for inputs that feed combinational
// paths). The AXI responder is played inline by run_txn. It serves reads from
// resp_mem and stores whatever the bridge puts on the W channel. A separate
// model_mem is updated only from the request (write buffer + strobe), so a
// readback compares the bridge's real write traffic with the intended result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_master_bridge;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [3:0]  req_strb;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [7:0]  wd_idx;
  logic [31:0] wd_data;
  logic        done, err;
  logic [3:0]  arid, arcache, awid, awcache, rid, wid, wstrb, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot, state_dbg;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_master_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_strb(req_strb),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wd_idx(wd_idx), .wd_data(wd_data), .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .state_dbg(state_dbg)
  );

  // memories and the requester's line buffer
  logic [31:0] resp_mem  [0:255];
  logic [31:0] model_mem [0:255];
  logic [31:0] wbuf      [0:15];
  assign wd_data = wbuf[wd_idx[3:0]];

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  // one stimulus record: request fields, responder behaviour, expected err
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  strb;
    int          ar_delay;   // ready-low cycles on AR/AW (also B delay mod 3)
    int          stall;      // 0 none, 1 every other cycle, 2 random
    int          last_beat;  // beat carrying rlast (reads)
    logic [1:0]  resp;       // rresp on last beat / bresp
    logic [3:0]  id_r;       // rid on last beat / bid
    int          rst_beat;   // read beat at which rst is asserted, -1 none
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [7:0] len,
                              logic [2:0] size, logic [3:0] strb, int d,
                              int st, int lb, logic [1:0] resp,
                              logic [3:0] id, int rb, bit e);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.strb = strb;
    v.ar_delay = d; v.stall = st; v.last_beat = lb; v.resp = resp;
    v.id_r = id; v.rst_beat = rb; v.exp_err = e;
    return v;
  endfunction

  // word index of beat i of an INCR burst
  function automatic int widx(logic [31:0] a, int i, logic [2:0] s);
    logic [31:0] b;
    b = a + (32'(i) << s);
    return int'(b[9:2]);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic bit stall_now(int mode, int k);
    if (mode == 1) return (k % 2) == 0;
    if (mode == 2) return $urandom_range(0, 2) == 0;
    return 1'b0;
  endfunction

  // Run one transaction starting on a falling edge. Returns the acceptance
  // cycle, the first address-valid cycle and the done cycle (-1 if none).
  task automatic run_txn(input vec_t v, input bit hold, output int acc_c,
                         output int addr_c, output int done_c);
    int guard, i, k, bd, bad;
    bit rdy;
    logic [31:0] ed;
    acc_c = -1; addr_c = -1; done_c = -1; bad = 0;
    if (v.wr) for (int j = 0; j < 16; j++) wbuf[j] = $urandom;
    req_wr = v.wr; req_addr = v.addr; req_len = v.len; req_size = v.size;
    req_strb = v.strb; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      check("req_accept", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    acc_c = cyc;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    addr_c = cyc;

    // address phase: valid and payload must hold through every ready-low cycle
    for (k = 0; k <= v.ar_delay; k++) begin
      if (v.wr) begin
        if (arvalid | rready | done) bad++;
        check("aw_valid", awvalid, 1'b1);
        check("aw_addr", awaddr, v.addr);
        check("aw_len", awlen, v.len);
        check("aw_size", awsize, v.size);
        check("aw_burst_id", {awburst, awid}, {2'b01, 4'd1});
        check("aw_const", {awlock, awcache, awprot}, 0);
        awready = (k == v.ar_delay);
      end else begin
        if (awvalid | wvalid | bready | done) bad++;
        check("ar_valid", arvalid, 1'b1);
        check("ar_addr", araddr, v.addr);
        check("ar_len", arlen, v.len);
        check("ar_size", arsize, v.size);
        check("ar_burst_id", {arburst, arid}, {2'b01, 4'd0});
        check("ar_const", {arlock, arcache, arprot}, 0);
        arready = (k == v.ar_delay);
      end
      @(negedge clk);
    end
    arready = 1'b0; awready = 1'b0;

    if (!v.wr) begin
      i = 0; k = 0; guard = 0;
      while (i <= v.last_beat && guard < 200) begin
        guard++;
        if (awvalid | wvalid | bready | done | arvalid) bad++;
        if (stall_now(v.stall, k)) begin
          rvalid = 1'b0;
          #1;
          check("r_gap_rd_valid", rd_valid, 1'b0);
          check("r_rready", rready, 1'b1);
        end else begin
          ed = model_mem[widx(v.addr, i, v.size)];
          rvalid = 1'b1;
          rdata  = resp_mem[widx(v.addr, i, v.size)];
          rlast  = (i == v.last_beat);
          rresp  = (i == v.last_beat) ? v.resp : 2'b00;
          rid    = (i == v.last_beat) ? v.id_r : 4'd0;
          #1;
          check("r_rready", rready, 1'b1);
          check("rd_valid", rd_valid, 1'b1);
          check("rd_data", rd_data, ed);
          check("rd_last", rd_last, (i == v.last_beat));
          if (i == v.rst_beat) begin
            // asynchronous reset in the middle of a beat
            rst = 1'b1;
            #1;
            check("rst_valids", {arvalid, awvalid, wvalid, rd_valid}, 0);
            check("rst_readies", {rready, bready}, 0);
            check("rst_done", done, 1'b0);
            check("rst_req_ready", req_ready, 1'b1);
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
            for (int j = 0; j < 3; j++) begin
              @(negedge clk);
              check("rst_no_done", done, 1'b0);
              check("rst_hold_ready", req_ready, 1'b1);
              if (j == 1) rst = 1'b0;
            end
            return;
          end
          i++;
        end
        k++;
        @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0;
      check("r_complete", i, v.last_beat + 1);
    end else begin
      i = 0; k = 0; guard = 0;
      while (i <= int'(v.len) && guard < 200) begin
        guard++;
        if (arvalid | rready | done | awvalid) bad++;
        rdy = !stall_now(v.stall, k);
        wready = rdy;
        #1;
        check("w_valid", wvalid, 1'b1);
        check("w_idx", wd_idx, i);
        check("w_data", wdata, wbuf[i]);
        check("w_strb", wstrb, v.strb);
        check("w_last", wlast, (i == int'(v.len)));
        check("w_id", wid, 4'd1);
        if (rdy && wvalid) begin
          resp_mem[widx(v.addr, i, v.size)] =
            merge(resp_mem[widx(v.addr, i, v.size)], wdata, wstrb);
          model_mem[widx(v.addr, i, v.size)] =
            merge(model_mem[widx(v.addr, i, v.size)], wbuf[i], v.strb);
          i++;
        end
        k++;
        @(negedge clk);
      end
      wready = 1'b0;
      check("w_complete", i, int'(v.len) + 1);
      bd = v.ar_delay % 3;
      for (k = 0; k <= bd; k++) begin
        if (wvalid | done) bad++;
        check("b_ready", bready, 1'b1);
        if (k == bd) begin bvalid = 1'b1; bresp = v.resp; bid = v.id_r; end
        @(negedge clk);
      end
      bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    end

    check("done", done, 1'b1);
    check("err", err, v.exp_err);
    check("txn_protocol", bad, 0);
    done_c = cyc;
    // accept, AR, len+1 beats, DONE: the span from acceptance through done
    if (!v.wr && v.ar_delay == 0 && v.stall == 0 && v.last_beat == int'(v.len))
      check("rd_latency", done_c - acc_c + 1, int'(v.len) + 4);
  endtask

  // watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  vec_t tbl[12];
  vec_t v;
  vec_t b2b[4];
  int   a, ad, d, prev_done;
  int   sel;

  initial begin
    // table of directed vectors: request, responder behaviour, expected err
    tbl[0]  = mk(0, 32'h1FC0_0000, 0, 2, 4'h0, 0, 0, 0, 2'b00, 4'd0, -1, 0);
    tbl[1]  = mk(0, 32'h0000_0100, 7, 2, 4'h0, 3, 0, 7, 2'b00, 4'd0, -1, 0);
    tbl[2]  = mk(1, 32'h0000_0200, 3, 2, 4'hF, 0, 1, 3, 2'b00, 4'd1, -1, 0);
    tbl[3]  = mk(0, 32'h0000_0200, 3, 2, 4'h0, 0, 0, 3, 2'b00, 4'd0, -1, 0);
    tbl[4]  = mk(1, 32'h0000_0300, 1, 2, 4'hF, 1, 0, 1, 2'b10, 4'd1, -1, 1);
    tbl[5]  = mk(0, 32'h0000_0040, 3, 2, 4'h0, 0, 0, 2, 2'b00, 4'd0, -1, 1);
    tbl[6]  = mk(0, 32'h0000_0080, 2, 2, 4'h0, 0, 0, 2, 2'b00, 4'd5, -1, 1);
    tbl[7]  = mk(1, 32'h0000_0380, 0, 2, 4'hF, 0, 0, 0, 2'b00, 4'd3, -1, 1);
    tbl[8]  = mk(1, 32'h0000_0240, 2, 2, 4'h5, 2, 2, 2, 2'b00, 4'd1, -1, 0);
    tbl[9]  = mk(0, 32'h0000_0240, 2, 2, 4'h0, 0, 2, 2, 2'b00, 4'd0, -1, 0);
    tbl[10] = mk(0, 32'h0000_0010, 5, 1, 4'h0, 0, 1, 5, 2'b00, 4'd0, -1, 0);
    tbl[11] = mk(0, 32'h0000_0020, 4, 2, 4'h0, 0, 0, 4, 2'b11, 4'd0, -1, 1);

    for (int j = 0; j < 256; j++) begin
      resp_mem[j] = $urandom;
      model_mem[j] = resp_mem[j];
    end
    resp_mem[0] = 32'hDEAD_BEEF;
    model_mem[0] = 32'hDEAD_BEEF;
    for (int j = 0; j < 16; j++) wbuf[j] = 32'd0;

    rst = 1'b1;
    req_valid = 0; req_wr = 0; req_addr = 0; req_len = 0; req_size = 0;
    req_strb = 0; arready = 0; awready = 0; wready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    bvalid = 0; bresp = 0; bid = 0;
    repeat (3) @(negedge clk);

    // reset state
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_arvalid", arvalid, 1'b0);
    check("reset_awvalid", awvalid, 1'b0);
    check("reset_wvalid", wvalid, 1'b0);
    check("reset_rready", rready, 1'b0);
    check("reset_bready", bready, 1'b0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_done_err", {done, err}, 2'b00);
    check("reset_wlast", wlast, 1'b0);
    check("reset_cnt", wd_idx, 8'd0);
    check("reset_araddr", araddr, 32'd0);
    check("reset_arlen", arlen, 8'd0);
    check("reset_awaddr", awaddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed table
    for (int t = 0; t < 12; t++) begin
      run_txn(tbl[t], 1'b0, a, ad, d);
      check("addr_after_accept", ad - a, 1);
      if (t == 0) check("single_read_word", model_mem[0], 32'hDEAD_BEEF);
      @(negedge clk);
    end

    // reset during beat 4 of an 8-beat read, then a clean single read
    v = mk(0, 32'h0000_0180, 7, 2, 4'h0, 0, 0, 7, 2'b00, 4'd0, 4, 0);
    run_txn(v, 1'b0, a, ad, d);
    check("rst_no_done_cycle", d, -1);
    run_txn(tbl[0], 1'b0, a, ad, d);
    @(negedge clk);

    // back-to-back with req_valid held high, alternating read/write
    b2b[0] = mk(0, 32'h0000_0200, 3, 2, 4'h0, 0, 0, 3, 2'b00, 4'd0, -1, 0);
    b2b[1] = mk(1, 32'h0000_0280, 2, 2, 4'hF, 0, 0, 2, 2'b00, 4'd1, -1, 0);
    b2b[2] = mk(0, 32'h0000_0280, 2, 2, 4'h0, 0, 0, 2, 2'b00, 4'd0, -1, 0);
    b2b[3] = mk(1, 32'h0000_02C0, 1, 2, 4'h3, 1, 1, 1, 2'b00, 4'd1, -1, 0);
    prev_done = -1;
    for (int t = 0; t < 4; t++) begin
      run_txn(b2b[t], (t != 3), a, ad, d);
      if (t > 0) check("b2b_gap", ad - prev_done, 2);
      prev_done = d;
    end
    req_valid = 1'b0;
    @(negedge clk);

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.len = 8'($urandom_range(0, 15));
      v.size = 3'($urandom_range(0, 2));
      v.addr = 32'($urandom_range(0, 255)) << 2;
      v.strb = 4'($urandom);
      v.ar_delay = $urandom_range(0, 3);
      v.stall = $urandom_range(0, 2);
      v.last_beat = int'(v.len);
      v.resp = 2'b00;
      v.id_r = v.wr ? 4'd1 : 4'd0;
      v.rst_beat = -1;
      sel = $urandom_range(0, 9);
      if (sel == 0) v.resp = 2'($urandom_range(1, 3));
      else if (sel == 1) v.id_r = 4'($urandom_range(2, 15));
      else if (sel == 2 && !v.wr && v.len > 0)
        v.last_beat = $urandom_range(0, int'(v.len) - 1);
      v.exp_err = (v.resp != 2'b00) || (v.id_r != (v.wr ? 4'd1 : 4'd0)) ||
                  (!v.wr && v.last_beat != int'(v.len));
      run_txn(v, 1'b0, a, ad, d);
      check("rand_done_seen", (d >= 0), 1'b1);
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
